// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with an iterative restoring divider.
// Operands are transferred on IN_VALID & IN_READY; results and flags are
// registered and qualified by a one-cycle OUT_VALID pulse.
// Optional feature macro: ALU_ROT_EN (opcodes 14/15 become rotate right/left;
// without it they report ILLEGAL_OP).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | ready for a new op; single-cycle ops complete from here
//  ST_DIV  | dividing; IN_VALID ignored until the quotient is complete
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [2*DATA_WIDTH-1:0] ALU_OUT,
    output logic                    OUT_VALID,
    output logic                    DIV_BY_ZERO,
    output logic                    ILLEGAL_OP
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [FUN_WIDTH-1:0] OP_ADD  = FUN_WIDTH'(0);
    localparam logic [FUN_WIDTH-1:0] OP_SUB  = FUN_WIDTH'(1);
    localparam logic [FUN_WIDTH-1:0] OP_MUL  = FUN_WIDTH'(2);
    localparam logic [FUN_WIDTH-1:0] OP_DIV  = FUN_WIDTH'(3);
    localparam logic [FUN_WIDTH-1:0] OP_AND  = FUN_WIDTH'(4);
    localparam logic [FUN_WIDTH-1:0] OP_OR   = FUN_WIDTH'(5);
    localparam logic [FUN_WIDTH-1:0] OP_NAND = FUN_WIDTH'(6);
    localparam logic [FUN_WIDTH-1:0] OP_NOR  = FUN_WIDTH'(7);
    localparam logic [FUN_WIDTH-1:0] OP_XOR  = FUN_WIDTH'(8);
    localparam logic [FUN_WIDTH-1:0] OP_XNOR = FUN_WIDTH'(9);
    localparam logic [FUN_WIDTH-1:0] OP_EQ   = FUN_WIDTH'(10);
    localparam logic [FUN_WIDTH-1:0] OP_GT   = FUN_WIDTH'(11);
    localparam logic [FUN_WIDTH-1:0] OP_SHR  = FUN_WIDTH'(12);
    localparam logic [FUN_WIDTH-1:0] OP_SHL  = FUN_WIDTH'(13);
`ifdef ALU_ROT_EN
    localparam logic [FUN_WIDTH-1:0] OP_ROR  = FUN_WIDTH'(14);
    localparam logic [FUN_WIDTH-1:0] OP_ROL  = FUN_WIDTH'(15);
`endif

    typedef enum logic {ST_IDLE, ST_DIV} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   div_b_q, div_b_d;
    logic [RW-1:0]           alu_out_q, alu_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    dbz_q, dbz_d;
    logic                    ill_q, ill_d;

    logic [RW-1:0]           a_ext, b_ext;
    logic [RW-1:0]           op_res;
    logic                    op_ill;
    logic [DATA_WIDTH:0]     trial;
    logic [DATA_WIDTH-1:0]   rem_step, quo_step;
    logic                    start_div;

    assign a_ext     = {{DATA_WIDTH{1'b0}}, A};
    assign b_ext     = {{DATA_WIDTH{1'b0}}, B};
    assign start_div = (ALU_FUN == OP_DIV) && (B != '0);

    // Single-cycle result for the presented opcode; divide entry covers B==0 only.
    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        case (ALU_FUN)
            OP_ADD:  op_res = a_ext + b_ext;
            OP_SUB:  op_res = a_ext - b_ext;
            OP_MUL:  op_res = a_ext * b_ext;
            OP_DIV:  op_res = {A, {DATA_WIDTH{1'b1}}};
            OP_AND:  op_res = {{DATA_WIDTH{1'b0}}, A & B};
            OP_OR:   op_res = {{DATA_WIDTH{1'b0}}, A | B};
            OP_NAND: op_res = {{DATA_WIDTH{1'b0}}, ~(A & B)};
            OP_NOR:  op_res = {{DATA_WIDTH{1'b0}}, ~(A | B)};
            OP_XOR:  op_res = {{DATA_WIDTH{1'b0}}, A ^ B};
            OP_XNOR: op_res = {{DATA_WIDTH{1'b0}}, ~(A ^ B)};
            OP_EQ:   op_res = {{(RW-1){1'b0}}, (A == B)};
            OP_GT:   op_res = {{(RW-1){1'b0}}, (A > B)};
            OP_SHR:  op_res = {{DATA_WIDTH{1'b0}}, A >> 1};
            OP_SHL:  op_res = {{(DATA_WIDTH-1){1'b0}}, A, 1'b0};
`ifdef ALU_ROT_EN
            OP_ROR:  op_res = {{DATA_WIDTH{1'b0}}, A[0], A[DATA_WIDTH-1:1]};
            OP_ROL:  op_res = {{DATA_WIDTH{1'b0}}, A[DATA_WIDTH-2:0], A[DATA_WIDTH-1]};
`endif
            default: op_ill = 1'b1;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_step = trial[DATA_WIDTH-1:0];
        quo_step = {quo_q[DATA_WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, div_b_q}) begin
            rem_step = DATA_WIDTH'(trial - {1'b0, div_b_q});
            quo_step = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and datapath control. The DIV state spends DATA_WIDTH cycles
    // iterating and one more cycle (counter at zero) registering the result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_b_d     = div_b_q;
        alu_out_d   = alu_out_q;
        out_valid_d = 1'b0;
        dbz_d       = 1'b0;
        ill_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    if (start_div) begin
                        state_d = ST_DIV;
                        cnt_d   = CW'(DATA_WIDTH);
                        rem_d   = '0;
                        quo_d   = A;
                        div_b_d = B;
                    end else begin
                        alu_out_d   = op_res;
                        out_valid_d = 1'b1;
                        ill_d       = op_ill;
                        dbz_d       = (ALU_FUN == OP_DIV);
                    end
                end
            end
            ST_DIV: begin
                if (cnt_q != '0) begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    alu_out_d   = {rem_q, quo_q};
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any division in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_b_q     <= '0;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_b_q     <= div_b_d;
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
        end
    end

    assign IN_READY    = (state_q == ST_IDLE);
    assign ALU_OUT     = alu_out_q;
    assign OUT_VALID   = out_valid_q;
    assign DIV_BY_ZERO = dbz_q;
    assign ILLEGAL_OP  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (DATA_WIDTH=8). Honours ALU_ROT_EN like the design.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a, b;
    logic [3:0]  fun;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_out;
    logic        out_valid, div_by_zero, illegal_op;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] last_out = '0;

    typedef struct {
        logic [15:0] out;
        bit          dbz;
        bit          ill;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        logic [15:0] out;
        bit          dbz;
        bit          ill;
    } vec_t;

    exp_t sb[$];
    vec_t vt[24];

    alu_seq #(.DATA_WIDTH(8), .FUN_WIDTH(4)) dut (
        .CLK(clk), .RST(rst_n), .A(a), .B(b), .ALU_FUN(fun),
        .IN_VALID(in_valid), .IN_READY(in_ready), .ALU_OUT(alu_out),
        .OUT_VALID(out_valid), .DIV_BY_ZERO(div_by_zero), .ILLEGAL_OP(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mf);
        exp_t e;
        e.out = '0; e.dbz = 0; e.ill = 0; e.due = 0;
        case (mf)
            4'd0:  e.out = 16'(ma) + 16'(mb);
            4'd1:  e.out = 16'(ma) - 16'(mb);
            4'd2:  e.out = 16'(ma) * 16'(mb);
            4'd3:  if (mb == 0) begin e.out = {ma, 8'hFF}; e.dbz = 1; end
                   else e.out = {ma % mb, ma / mb};
            4'd4:  e.out = {8'h00, ma & mb};
            4'd5:  e.out = {8'h00, ma | mb};
            4'd6:  e.out = {8'h00, ~(ma & mb)};
            4'd7:  e.out = {8'h00, ~(ma | mb)};
            4'd8:  e.out = {8'h00, ma ^ mb};
            4'd9:  e.out = {8'h00, ~(ma ^ mb)};
            4'd10: e.out = (ma == mb) ? 16'd1 : 16'd0;
            4'd11: e.out = (ma > mb) ? 16'd1 : 16'd0;
            4'd12: e.out = {9'd0, ma[7:1]};
            4'd13: e.out = {7'd0, ma, 1'b0};
`ifdef ALU_ROT_EN
            4'd14: e.out = {8'h00, ma[0], ma[7:1]};
            4'd15: e.out = {8'h00, ma[6:0], ma[7]};
`else
            default: e.ill = 1;
`endif
        endcase
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
        end else begin
            if (sb.size() != 0 && cyc > sb[0].due) begin
                total++; bad++;
                $display("FAIL missing_output due_cycle=%0d now=%0d exp=%h", sb[0].due, cyc, sb[0].out);
                void'(sb.pop_front());
            end
            if (out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out_valid cycle=%0d got=%h", cyc, alu_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (alu_out !== e.out || div_by_zero !== e.dbz || illegal_op !== e.ill || cyc != e.due) begin
                        bad++;
                        $display("FAIL result cycle=%0d got out=%h dbz=%b ill=%b, required out=%h dbz=%b ill=%b at cycle %0d",
                                 cyc, alu_out, div_by_zero, illegal_op, e.out, e.dbz, e.ill, e.due);
                    end
                end
                last_out = alu_out;
            end else begin
                total++;
                if (div_by_zero !== 1'b0 || illegal_op !== 1'b0 || alu_out !== last_out) begin
                    bad++;
                    $display("FAIL idle_outputs cycle=%0d got out=%h dbz=%b ill=%b, required out=%h dbz=0 ill=0",
                             cyc, alu_out, div_by_zero, illegal_op, last_out);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Wait (bounded) for IN_READY, present one op for one edge, record expectation.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] ifn,
                         input logic [15:0] eo, input bit ed, input bit ei);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 100) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout cycle=%0d", cyc);
        end else begin
            a = ia; b = ib; fun = ifn; in_valid = 1'b1;
            e.out = eo; e.dbz = ed; e.ill = ei;
            e.due = cyc + 1 + ((ifn == 4'd3 && ib != 0) ? 9 : 0);
            sb.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int lowcnt;
        exp_t e;
        vt[0]  = '{8'd200, 8'd100, 4'd0,  16'h012C, 1'b0, 1'b0};
        vt[1]  = '{8'd255, 8'd255, 4'd0,  16'h01FE, 1'b0, 1'b0};
        vt[2]  = '{8'd3,   8'd5,   4'd1,  16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{8'd0,   8'd1,   4'd1,  16'hFFFF, 1'b0, 1'b0};
        vt[4]  = '{8'd255, 8'd255, 4'd2,  16'hFE01, 1'b0, 1'b0};
        vt[5]  = '{8'd100, 8'd7,   4'd3,  16'h020E, 1'b0, 1'b0};
        vt[6]  = '{8'd55,  8'd0,   4'd3,  16'h37FF, 1'b1, 1'b0};
        vt[7]  = '{8'd255, 8'd1,   4'd3,  16'h00FF, 1'b0, 1'b0};
        vt[8]  = '{8'd200, 8'd13,  4'd3,  16'h050F, 1'b0, 1'b0};
        vt[9]  = '{8'd7,   8'd9,   4'd3,  16'h0700, 1'b0, 1'b0};
        vt[10] = '{8'hF0,  8'h3C,  4'd4,  16'h0030, 1'b0, 1'b0};
        vt[11] = '{8'hF0,  8'h3C,  4'd5,  16'h00FC, 1'b0, 1'b0};
        vt[12] = '{8'hF0,  8'h3C,  4'd6,  16'h00CF, 1'b0, 1'b0};
        vt[13] = '{8'hF0,  8'h3C,  4'd7,  16'h0003, 1'b0, 1'b0};
        vt[14] = '{8'hF0,  8'h3C,  4'd8,  16'h00CC, 1'b0, 1'b0};
        vt[15] = '{8'hF0,  8'h3C,  4'd9,  16'h0033, 1'b0, 1'b0};
        vt[16] = '{8'd5,   8'd5,   4'd10, 16'h0001, 1'b0, 1'b0};
        vt[17] = '{8'd5,   8'd6,   4'd10, 16'h0000, 1'b0, 1'b0};
        vt[18] = '{8'd9,   8'd3,   4'd11, 16'h0001, 1'b0, 1'b0};
        vt[19] = '{8'd3,   8'd3,   4'd11, 16'h0000, 1'b0, 1'b0};
        vt[20] = '{8'h81,  8'd0,   4'd12, 16'h0040, 1'b0, 1'b0};
        vt[21] = '{8'h81,  8'd0,   4'd13, 16'h0102, 1'b0, 1'b0};
`ifdef ALU_ROT_EN
        vt[22] = '{8'h81,  8'd0,   4'd14, 16'h00C0, 1'b0, 1'b0};
        vt[23] = '{8'h81,  8'd0,   4'd15, 16'h0003, 1'b0, 1'b0};
`else
        vt[22] = '{8'h81,  8'd0,   4'd14, 16'h0000, 1'b0, 1'b1};
        vt[23] = '{8'h81,  8'd0,   4'd15, 16'h0000, 1'b0, 1'b1};
`endif

        // Reset state
        rst_n = 1'b0; a = '0; b = '0; fun = '0; in_valid = 1'b0;
        #13;
        check("reset_alu_out",   32'(alu_out),     32'h0);
        check("reset_out_valid", 32'(out_valid),   32'h0);
        check("reset_dbz",       32'(div_by_zero), 32'h0);
        check("reset_ill",       32'(illegal_op),  32'h0);
        check("reset_in_ready",  32'(in_ready),    32'h1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, one op at a time
        for (int i = 0; i < 24; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].fun, vt[i].out, vt[i].dbz, vt[i].ill);
            idle(1);
            drain();
        end

        // Divide by zero keeps IN_READY high
        issue(8'd55, 8'd0, 4'd3, 16'h37FF, 1'b1, 1'b0);
        check("dbz_ready_high", 32'(in_ready), 32'h1);
        drain();

        // Back-to-back single-cycle ops on consecutive cycles
        issue(8'd255, 8'd255, 4'd2, 16'hFE01, 1'b0, 1'b0);
        issue(8'd3,   8'd5,   4'd1, 16'hFFFE, 1'b0, 1'b0);
        issue(8'd10,  8'd20,  4'd0, 16'h001E, 1'b0, 1'b0);
        drain();

        // Divide: IN_READY low for 9 cycles, IN_VALID held with another op meanwhile,
        // then that op is accepted on the cycle IN_READY returns.
        issue(8'd100, 8'd7, 4'd3, 16'h020E, 1'b0, 1'b0);
        a = 8'd1; b = 8'd2; fun = 4'd0; in_valid = 1'b1;
        lowcnt = 0;
        while (!in_ready && lowcnt < 50) begin
            lowcnt++;
            @(posedge clk); #1;
        end
        check("div_ready_low_cycles", 32'(lowcnt), 32'd9);
        e.out = 16'h0003; e.dbz = 0; e.ill = 0; e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Divide followed immediately by a single-cycle op
        issue(8'd200, 8'd13, 4'd3, 16'h050F, 1'b0, 1'b0);
        issue(8'd5,   8'd5,  4'd10, 16'h0001, 1'b0, 1'b0);
        drain();

        // Reset during the 4th divide cycle aborts the divide
        issue(8'd100, 8'd7, 4'd3, 16'h020E, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        sb.delete();
        #1 rst_n = 1'b0;
        #1;
        check("midreset_alu_out",   32'(alu_out),   32'h0);
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_in_ready",  32'(in_ready),  32'h1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_in_ready", 32'(in_ready), 32'h1);
        issue(8'd1, 8'd1, 4'd0, 16'h0002, 1'b0, 1'b0);
        drain();
        idle(15);

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rf;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rf = 4'($urandom_range(0, 15));
            e = model(ra, rb, rf);
            issue(ra, rb, rf, e.out, e.dbz, e.ill);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
